wt_mem_req_arbiter: RTL and testbench

- Shares the single cached-memory request port among the instruction-cache refill path, the write-through data-cache miss path and the data-cache write buffer.
- Arbitration is round-robin.
- Each accepted request gets a transaction ID from a free pool. Out-of-order returns are routed back to the requester that owns the ID.
- Sits between the L1 caches and the AXI adapter in the FPGA softcore.

---
 rtl/wt_mem_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wt_mem_req_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the cached-memory request port among the
// icache refill path, the dcache miss path and the dcache write buffer.
// Every accepted request takes a transaction ID from a free pool; responses
// are routed back to the requester that owns the returned ID.
module wt_mem_req_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned TID_WIDTH  = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    output logic                          mem_req_we_o,
    output logic [DATA_WIDTH-1:0]         mem_req_wdata_o,
    output logic [TID_WIDTH-1:0]          mem_req_tid_o,
    input  logic                          rtrn_valid_i,
    input  logic [TID_WIDTH-1:0]          rtrn_tid_i,
    input  logic [LINE_WIDTH-1:0]         rtrn_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [LINE_WIDTH-1:0]         rsp_data_o,
    output logic [TID_WIDTH:0]            outstanding_o,
    output logic                          err_tid_o
);

    localparam int unsigned POOL  = 2**TID_WIDTH;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Output slot
    logic                  slot_valid_q, slot_valid_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q,  slot_addr_d;
    logic                  slot_we_q,    slot_we_d;
    logic [DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
    logic [TID_WIDTH-1:0]  slot_tid_q,   slot_tid_d;

    // ID pool (1 = allocated), owner table, round-robin pointer, ID count
    logic [POOL-1:0]             pool_q,  pool_d;
    logic [POOL-1:0][IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]            ptr_q,   ptr_d;
    logic [TID_WIDTH:0]          outst_q, outst_d;

    logic                  slot_free;
    logic                  pool_avail;
    logic                  req_found;
    logic                  grant;
    logic                  rtrn_hit;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      winner;
    logic [TID_WIDTH-1:0]  free_tid;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Grant logic: round-robin search from the pointer, lowest free ID, winner payload mux.
    always_comb begin
        slot_free  = !slot_valid_q || mem_req_ready_i;
        pool_avail = ~&pool_q;
        req_found  = 1'b0;
        cand       = '0;
        winner     = '0;
        free_tid   = '0;
        win_addr   = '0;
        win_we     = 1'b0;
        win_wdata  = '0;
        req_ready_o = '0;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!req_found && req_valid_i[cand]) begin
                req_found = 1'b1;
                winner    = cand;
            end
        end

        // Downward scan leaves the lowest-index free ID in free_tid.
        for (int unsigned t = POOL; t > 0; t--) begin
            if (!pool_q[TID_WIDTH'(t - 1)]) begin
                free_tid = TID_WIDTH'(t - 1);
            end
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                win_addr  = ADDR_WIDTH'(req_addr_i >> (i * ADDR_WIDTH));
                win_we    = req_we_i[IDX_W'(i)];
                win_wdata = DATA_WIDTH'(req_wdata_i >> (i * DATA_WIDTH));
            end
        end

        // Held low during reset so every output reads 0 while rst_ni is low.
        grant = rst_ni && req_found && slot_free && pool_avail;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Response routing: strobe the owner of an allocated ID, flag unallocated IDs.
    always_comb begin
        rtrn_hit    = rtrn_valid_i && pool_q[rtrn_tid_i];
        err_tid_o   = rst_ni && rtrn_valid_i && !pool_q[rtrn_tid_i];
        rsp_data_o  = rtrn_data_i;
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rtrn_hit && owner_q[rtrn_tid_i] == IDX_W'(i)) begin
                rsp_valid_o[IDX_W'(i)] = 1'b1;
            end
        end
    end

    // Next state for slot, pool, owners, pointer and outstanding count.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_we_d    = slot_we_q;
        slot_wdata_d = slot_wdata_q;
        slot_tid_d   = slot_tid_q;
        pool_d       = pool_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;

        // Free and allocate never touch the same ID: allocation only picks IDs
        // that are clear in the registered pool, a hit only clears set ones.
        if (rtrn_hit) begin
            pool_d[rtrn_tid_i] = 1'b0;
        end

        if (grant) begin
            slot_valid_d      = 1'b1;
            slot_addr_d       = win_addr;
            slot_we_d         = win_we;
            slot_wdata_d      = win_wdata;
            slot_tid_d        = free_tid;
            pool_d[free_tid]  = 1'b1;
            owner_d[free_tid] = winner;
            ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (slot_valid_q && mem_req_ready_i) begin
            slot_valid_d = 1'b0;
        end

        outst_d = outst_q + (TID_WIDTH+1)'(grant) - (TID_WIDTH+1)'(rtrn_hit);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_we_q    <= 1'b0;
            slot_wdata_q <= '0;
            slot_tid_q   <= '0;
            pool_q       <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            outst_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_we_q    <= slot_we_d;
            slot_wdata_q <= slot_wdata_d;
            slot_tid_q   <= slot_tid_d;
            pool_q       <= pool_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            outst_q      <= outst_d;
        end
    end

    assign mem_req_valid_o = slot_valid_q;
    assign mem_req_addr_o  = slot_addr_q;
    assign mem_req_we_o    = slot_we_q;
    assign mem_req_wdata_o = slot_wdata_q;
    assign mem_req_tid_o   = slot_tid_q;
    assign outstanding_o   = outst_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Bench for wt_mem_req_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_wt_mem_req_arbiter;

    localparam int NR = 3;
    localparam int TW = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 128;
    localparam int POOL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_we;
    logic [AW-1:0]    r_addr [NR];
    logic [DW-1:0]    r_wdata [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [AW-1:0]    mem_req_addr;
    logic             mem_req_we;
    logic [DW-1:0]    mem_req_wdata;
    logic [TW-1:0]    mem_req_tid;
    logic             rtrn_valid;
    logic [TW-1:0]    rtrn_tid;
    logic [LW-1:0]    rtrn_data;
    logic [NR-1:0]    rsp_valid;
    logic [LW-1:0]    rsp_data;
    logic [TW:0]      outstanding;
    logic             err_tid;

    assign req_addr  = {r_addr[2], r_addr[1], r_addr[0]};
    assign req_wdata = {r_wdata[2], r_wdata[1], r_wdata[0]};

    wt_mem_req_arbiter #(
        .NUM_REQ   (NR),
        .TID_WIDTH (TW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_wdata_i    (req_wdata),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o (mem_req_addr),
        .mem_req_we_o   (mem_req_we),
        .mem_req_wdata_o(mem_req_wdata),
        .mem_req_tid_o  (mem_req_tid),
        .rtrn_valid_i   (rtrn_valid),
        .rtrn_tid_i     (rtrn_tid),
        .rtrn_data_i    (rtrn_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .outstanding_o  (outstanding),
        .err_tid_o      (err_tid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: set of allocated IDs with owners, RR pointer,
    // the request waiting in the output slot, and IDs handed to memory.
    bit          m_alloc [POOL];
    int          m_owner [POOL];
    int          m_ptr;
    bit          m_sv;
    logic [AW-1:0] m_saddr;
    bit          m_swe;
    logic [DW-1:0] m_swdata;
    int          m_stid;
    int          inflight [$];
    bit          pend [NR];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_alloc();
        int c = 0;
        for (int t = 0; t < POOL; t++) c += m_alloc[t];
        return c;
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < POOL; t++) if (!m_alloc[t]) return t;
        return -1;
    endfunction

    // Winner index, or -1 when no grant is due this cycle.
    function automatic int pick_winner();
        if (!rst_n) return -1;
        if (m_sv && !mem_req_ready) return -1;
        if (count_alloc() == POOL) return -1;
        for (int k = 0; k < NR; k++) begin
            int r = (m_ptr + k) % NR;
            if (req_valid[r]) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < POOL; t++) begin
            m_alloc[t] = 0;
            m_owner[t] = 0;
        end
        for (int r = 0; r < NR; r++) pend[r] = 0;
        m_ptr = 0;
        m_sv = 0;
        m_saddr = '0;
        m_swe = 0;
        m_swdata = '0;
        m_stid = 0;
        inflight.delete();
    endtask

    task automatic check_all();
        logic [NR-1:0] e_ready;
        logic [NR-1:0] e_rsp;
        logic e_err;
        int w;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_mem_valid", mem_req_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err", err_tid, 0);
            return;
        end
        w = pick_winner();
        e_ready = '0;
        if (w >= 0) e_ready[w] = 1'b1;
        chk("req_ready", req_ready, e_ready);
        chk("mem_valid", mem_req_valid, m_sv);
        if (m_sv) begin
            chk("mem_addr", mem_req_addr, m_saddr);
            chk("mem_we", mem_req_we, m_swe);
            chk("mem_wdata", mem_req_wdata, m_swdata);
            chk("mem_tid", mem_req_tid, m_stid);
        end
        chk("outstanding", outstanding, count_alloc());
        e_rsp = '0;
        e_err = 1'b0;
        if (rtrn_valid) begin
            if (m_alloc[rtrn_tid]) e_rsp[m_owner[rtrn_tid]] = 1'b1;
            else e_err = 1'b1;
        end
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("err_tid", err_tid, e_err);
        if (|e_rsp) chk("rsp_data", rsp_data, rtrn_data);
    endtask

    task automatic model_advance();
        int w;
        int lf;
        w = pick_winner();
        lf = lowest_free();
        if (m_sv && mem_req_ready) inflight.push_back(m_stid);
        if (rtrn_valid && m_alloc[rtrn_tid]) m_alloc[rtrn_tid] = 0;
        if (w >= 0) begin
            m_sv = 1;
            m_saddr = r_addr[w];
            m_swe = req_we[w];
            m_swdata = r_wdata[w];
            m_stid = lf;
            m_alloc[lf] = 1;
            m_owner[lf] = w;
            m_ptr = (w + 1) % NR;
            pend[w] = 0;
        end else if (m_sv && mem_req_ready) begin
            m_sv = 0;
        end
    endtask

    task automatic sample_chk();
        #2;
        check_all();
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (rst_n) model_advance();
        #1;
    endtask

    task automatic zero_inputs();
        req_valid = '0;
        req_we = '0;
        for (int r = 0; r < NR; r++) begin
            r_addr[r] = '0;
            r_wdata[r] = '0;
        end
        mem_req_ready = 1'b0;
        rtrn_valid = 1'b0;
        rtrn_tid = '0;
        rtrn_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        sample_chk();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int gq [$];
    int tq [$];

    initial begin
        zero_inputs();
        do_reset();

        // Single read on requester 0
        sample_chk();
        clk_edge();
        req_valid = 3'b001;
        r_addr[0] = 64'h8000_0040;
        mem_req_ready = 1'b1;
        sample_chk();
        chk("t1_ready", req_ready, 3'b001);
        clk_edge();
        req_valid = '0;
        sample_chk();
        chk("t1_mem_valid", mem_req_valid, 1'b1);
        chk("t1_mem_addr", mem_req_addr, 64'h8000_0040);
        chk("t1_mem_tid", mem_req_tid, 0);
        chk("t1_outstanding", outstanding, 1);
        clk_edge();
        rtrn_valid = 1'b1;
        rtrn_tid = 2'd0;
        rtrn_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        sample_chk();
        chk("t1_rsp", rsp_valid, 3'b001);
        clk_edge();
        rtrn_valid = 1'b0;
        sample_chk();
        chk("t1_outstanding_end", outstanding, 0);
        clk_edge();

        // All requesters valid, responses start once the pool is full
        zero_inputs();
        do_reset();
        for (int r = 0; r < NR; r++) r_addr[r] = 64'h1000 * (r + 1);
        mem_req_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 10) ? 3'b111 : 3'b000;
            rtrn_valid = 1'b0;
            if (c >= 4 && inflight.size() > 0) begin
                rtrn_valid = 1'b1;
                rtrn_tid = 2'(inflight.pop_front());
                rtrn_data = {64'(c), 64'hA5A5};
            end
            sample_chk();
            for (int r = 0; r < NR; r++) if (req_ready[r]) gq.push_back(r);
            if (mem_req_valid && mem_req_ready) tq.push_back(int'(mem_req_tid));
            clk_edge();
        end
        chk("t2_grant_count", gq.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            if (i < gq.size()) chk($sformatf("t2_grant%0d", i), gq[i], i % 3);
        chk("t2_tid_count", tq.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < tq.size()) chk($sformatf("t2_tid%0d", i), tq[i], i);

        // Pool exhaustion, then a single freed ID is reused
        zero_inputs();
        do_reset();
        mem_req_ready = 1'b1;
        req_valid = 3'b010;
        r_addr[1] = 64'h8000_0100;
        for (int c = 0; c < 4; c++) begin
            sample_chk();
            chk($sformatf("t3_ready%0d", c), req_ready, 3'b010);
            clk_edge();
        end
        sample_chk();
        chk("t3_full_ready", req_ready, 3'b000);
        chk("t3_full_outstanding", outstanding, 4);
        clk_edge();
        rtrn_valid = 1'b1;
        rtrn_tid = 2'd2;
        rtrn_data = 128'h22;
        sample_chk();
        chk("t3_rsp", rsp_valid, 3'b010);
        chk("t3_ready_same_cycle", req_ready, 3'b000);
        clk_edge();
        rtrn_valid = 1'b0;
        sample_chk();
        chk("t3_regrant", req_ready, 3'b010);
        chk("t3_outstanding3", outstanding, 3);
        clk_edge();
        req_valid = '0;
        sample_chk();
        chk("t3_reuse_tid", mem_req_tid, 2);
        clk_edge();

        // Backpressure on a write from requester 2
        zero_inputs();
        do_reset();
        req_valid = 3'b100;
        r_addr[2] = 64'h8000_1000;
        req_we = 3'b100;
        r_wdata[2] = 64'hDEAD_BEEF;
        sample_chk();
        chk("t4_ready", req_ready, 3'b100);
        clk_edge();
        req_valid = 3'b001;
        req_we = 3'b000;
        r_addr[0] = 64'h8000_2000;
        for (int c = 0; c < 5; c++) begin
            sample_chk();
            chk($sformatf("t4_hold_valid%0d", c), mem_req_valid, 1'b1);
            chk($sformatf("t4_hold_wdata%0d", c), mem_req_wdata, 64'hDEAD_BEEF);
            chk($sformatf("t4_hold_we%0d", c), mem_req_we, 1'b1);
            chk($sformatf("t4_hold_addr%0d", c), mem_req_addr, 64'h8000_1000);
            chk($sformatf("t4_nogrant%0d", c), req_ready, 3'b000);
            clk_edge();
        end
        mem_req_ready = 1'b1;
        sample_chk();
        chk("t4_drain_grant", req_ready, 3'b001);
        clk_edge();
        req_valid = '0;
        sample_chk();
        chk("t4_next_tid", mem_req_tid, 1);
        chk("t4_next_addr", mem_req_addr, 64'h8000_2000);
        chk("t4_next_we", mem_req_we, 1'b0);
        clk_edge();

        // Out-of-order and unexpected responses
        zero_inputs();
        do_reset();
        mem_req_ready = 1'b1;
        req_valid = 3'b001;
        sample_chk();
        clk_edge();
        req_valid = 3'b100;
        sample_chk();
        chk("t5_ready2", req_ready, 3'b100);
        clk_edge();
        req_valid = '0;
        sample_chk();
        clk_edge();
        rtrn_valid = 1'b1;
        rtrn_tid = 2'd1;
        rtrn_data = 128'h1111;
        sample_chk();
        chk("t5_rsp_tid1", rsp_valid, 3'b100);
        clk_edge();
        rtrn_tid = 2'd0;
        rtrn_data = 128'h0;
        sample_chk();
        chk("t5_rsp_tid0", rsp_valid, 3'b001);
        clk_edge();
        rtrn_tid = 2'd3;
        sample_chk();
        chk("t5_err", err_tid, 1'b1);
        chk("t5_err_rsp", rsp_valid, 3'b000);
        clk_edge();
        rtrn_valid = 1'b0;
        sample_chk();
        chk("t5_err_pulse_end", err_tid, 1'b0);
        clk_edge();

        // Reset with IDs in flight and the slot full
        zero_inputs();
        do_reset();
        mem_req_ready = 1'b1;
        req_valid = 3'b001;
        for (int c = 0; c < 3; c++) begin
            sample_chk();
            clk_edge();
        end
        mem_req_ready = 1'b0;
        sample_chk();
        chk("t6_outstanding3", outstanding, 3);
        chk("t6_slot_full", mem_req_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_valid", mem_req_valid, 1'b0);
        chk("t6_rst_ready", req_ready, 3'b000);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_rsp", rsp_valid, 3'b000);
        chk("t6_rst_err", err_tid, 1'b0);
        do_reset();
        mem_req_ready = 1'b1;
        sample_chk();
        chk("t6_post_ready", req_ready, 3'b001);
        clk_edge();
        req_valid = '0;
        rtrn_valid = 1'b1;
        rtrn_tid = 2'd1;
        sample_chk();
        chk("t6_post_tid", mem_req_tid, 0);
        chk("t6_stale_err", err_tid, 1'b1);
        chk("t6_stale_rsp", rsp_valid, 3'b000);
        clk_edge();
        rtrn_valid = 1'b0;

        // Random traffic with out-of-order returns and stray IDs
        zero_inputs();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && $urandom_range(0, 99) < 40) begin
                    pend[r] = 1;
                    r_addr[r] = {$urandom, $urandom};
                    req_we[r] = 1'($urandom_range(0, 1));
                    r_wdata[r] = {$urandom, $urandom};
                end
                req_valid[r] = pend[r];
            end
            mem_req_ready = ($urandom_range(0, 99) < 70);
            rtrn_valid = 1'b0;
            if (inflight.size() > 0 && $urandom_range(0, 99) < 45) begin
                int idx = $urandom_range(0, inflight.size() - 1);
                rtrn_valid = 1'b1;
                rtrn_tid = 2'(inflight[idx]);
                inflight.delete(idx);
                rtrn_data = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 99) < 5) begin
                int t = $urandom_range(0, POOL - 1);
                if (!m_alloc[t]) begin
                    rtrn_valid = 1'b1;
                    rtrn_tid = 2'(t);
                    rtrn_data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            sample_chk();
            clk_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
